// File: rtl/rv32i_alu_datapath_arbiter_if.sv
// Request, shared-datapath and response signals of the two-port ALU datapath arbiter.
// The arbiter uses the slave view; requesters, datapath slice and bench use the master view.
interface rv32i_alu_datapath_arbiter_if;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [2:0]  i_req_op0;
  logic [2:0]  i_req_op1;
  logic [31:0] i_req_a0;
  logic [31:0] i_req_b0;
  logic [31:0] i_req_a1;
  logic [31:0] i_req_b1;

  logic [15:0] o_dp_operand_one;
  logic [15:0] o_dp_operand_two;
  logic        o_dp_carry_in;
  logic [1:0]  o_dp_op_sel;
  logic [15:0] i_dp_result;
  logic        i_dp_carry_out;

  logic        o_rsp_valid;
  logic        o_rsp_id;
  logic [31:0] o_rsp_result;
  logic        o_rsp_carry;
  logic        o_rsp_err;
  logic        o_busy;

  modport slave (
    input  i_req_valid, i_req_op0, i_req_op1,
    input  i_req_a0, i_req_b0, i_req_a1, i_req_b1,
    input  i_dp_result, i_dp_carry_out,
    output o_req_ready,
    output o_dp_operand_one, o_dp_operand_two, o_dp_carry_in, o_dp_op_sel,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_rsp_err,
    output o_busy
  );

  modport master (
    output i_req_valid, i_req_op0, i_req_op1,
    output i_req_a0, i_req_b0, i_req_a1, i_req_b1,
    output i_dp_result, i_dp_carry_out,
    input  o_req_ready,
    input  o_dp_operand_one, o_dp_operand_two, o_dp_carry_in, o_dp_op_sel,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_rsp_err,
    input  o_busy
  );
endinterface

// File: rtl/rv32i_alu_datapath_arbiter.sv
// Shares one 16-bit ALU slice between two 32-bit requesters; each op runs as a
// low pass then a high pass with carry chaining, and is reassembled into one response.
//
// state | meaning
// IDLE  | no operation in flight, may accept
// LOW   | low 16 bits on the datapath
// HIGH  | high 16 bits on the datapath, carry from LOW chained in
// DONE  | response pulse, may accept the next request
module rv32i_alu_datapath_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  rv32i_alu_datapath_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_AND = 2'b01;
  localparam logic [1:0] SEL_OR  = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;

  logic [1:0]  grant;
  logic [1:0]  ready;
  logic        can_accept;
  logic        hs;
  logic        hs_id;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_legal;
  logic        is_sub;
  logic        is_arith;

  always_comb begin
    grant = 2'b00;
    case (bus.i_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign can_accept      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ready           = (can_accept && i_rst_n) ? grant : 2'b00;
  assign bus.o_req_ready = ready;
  assign hs              = |(bus.i_req_valid & ready);
  assign hs_id           = ready[1];

  assign sel_op    = hs_id ? bus.i_req_op1 : bus.i_req_op0;
  assign sel_a     = hs_id ? bus.i_req_a1  : bus.i_req_a0;
  assign sel_b     = hs_id ? bus.i_req_b1  : bus.i_req_b0;
  assign sel_legal = (sel_op <= OP_XOR);

  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (hs) begin
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = hs_id;
          lo_d    = 16'h0000;
          hi_d    = 16'h0000;
          carry_d = 1'b0;
          err_d   = ~sel_legal;
          state_d = sel_legal ? ST_LOW : ST_DONE;
        end
      end
      ST_LOW: begin
        lo_d    = bus.i_dp_result;
        carry_d = bus.i_dp_carry_out;
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        hi_d    = bus.i_dp_result;
        carry_d = is_arith & bus.i_dp_carry_out;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pointer points away from the port just served; fixed-priority mode pins it to port 0.
    if (!RR_EN)
      ptr_d = 1'b0;
    else if (hs)
      ptr_d = ~hs_id;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      op_q    <= 3'b000;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      id_q    <= 1'b0;
      lo_q    <= 16'h0;
      hi_q    <= 16'h0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // SUB is a + ~b + 1: invert b and seed the low pass with carry 1.
  always_comb begin
    bus.o_dp_operand_one = 16'h0000;
    bus.o_dp_operand_two = 16'h0000;
    bus.o_dp_carry_in    = 1'b0;
    bus.o_dp_op_sel      = SEL_ADD;
    if ((state_q == ST_LOW) || (state_q == ST_HIGH)) begin
      case (op_q)
        OP_AND:  bus.o_dp_op_sel = SEL_AND;
        OP_OR:   bus.o_dp_op_sel = SEL_OR;
        OP_XOR:  bus.o_dp_op_sel = SEL_XOR;
        default: bus.o_dp_op_sel = SEL_ADD;
      endcase
      if (state_q == ST_LOW) begin
        bus.o_dp_operand_one = a_q[15:0];
        bus.o_dp_operand_two = is_sub ? ~b_q[15:0] : b_q[15:0];
        bus.o_dp_carry_in    = is_sub;
      end else begin
        bus.o_dp_operand_one = a_q[31:16];
        bus.o_dp_operand_two = is_sub ? ~b_q[31:16] : b_q[31:16];
        bus.o_dp_carry_in    = is_arith & carry_q;
      end
    end
  end

  assign bus.o_rsp_valid  = (state_q == ST_DONE);
  assign bus.o_rsp_id     = (state_q == ST_DONE) & id_q;
  assign bus.o_rsp_result = (state_q == ST_DONE) ? {hi_q, lo_q} : 32'h0;
  assign bus.o_rsp_carry  = (state_q == ST_DONE) & carry_q;
  assign bus.o_rsp_err    = (state_q == ST_DONE) & err_q;
  assign bus.o_busy       = (state_q == ST_LOW) || (state_q == ST_HIGH);

endmodule

// File: tb/tb_rv32i_alu_datapath_arbiter.sv
// Directed bench for the ALU datapath arbiter: one round-robin and one fixed-priority
// instance, each attached to a behavioural 16-bit ALU slice.
module tb_rv32i_alu_datapath_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_alu_datapath_arbiter_if bus0 ();
  rv32i_alu_datapath_arbiter_if bus1 ();

  rv32i_alu_datapath_arbiter #(.RR_EN(1'b1)) dut_rr (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  rv32i_alu_datapath_arbiter #(.RR_EN(1'b0)) dut_fp (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  function automatic logic [16:0] dp_model(input logic [1:0] sel, input logic [15:0] a,
                                            input logic [15:0] b, input logic ci);
    case (sel)
      2'b00:   return {1'b0, a} + {1'b0, b} + {16'h0, ci};
      2'b01:   return {1'b0, a & b};
      2'b10:   return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {bus0.i_dp_carry_out, bus0.i_dp_result} =
    dp_model(bus0.o_dp_op_sel, bus0.o_dp_operand_one, bus0.o_dp_operand_two, bus0.o_dp_carry_in);
  assign {bus1.i_dp_carry_out, bus1.i_dp_result} =
    dp_model(bus1.o_dp_op_sel, bus1.o_dp_operand_one, bus1.o_dp_operand_two, bus1.o_dp_carry_in);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.i_req_valid = 2'b00; bus0.i_req_op0 = 3'd0; bus0.i_req_op1 = 3'd0;
    bus0.i_req_a0 = 32'h0; bus0.i_req_b0 = 32'h0; bus0.i_req_a1 = 32'h0; bus0.i_req_b1 = 32'h0;
    bus1.i_req_valid = 2'b00; bus1.i_req_op0 = 3'd0; bus1.i_req_op1 = 3'd0;
    bus1.i_req_a0 = 32'h0; bus1.i_req_b0 = 32'h0; bus1.i_req_a1 = 32'h0; bus1.i_req_b1 = 32'h0;
    rst_n = 1'b0;

    // Reset: ready held low even with a valid request pending
    repeat (2) @(negedge clk);
    bus0.i_req_valid = 2'b01;
    #1;
    chk("rst_ready", bus0.o_req_ready, 2'b00);
    chk("rst_busy", bus0.o_busy, 0);
    chk("rst_rsp_valid", bus0.o_rsp_valid, 0);
    chk("rst_rsp_result", bus0.o_rsp_result, 0);
    chk("rst_dp_sel", bus0.o_dp_op_sel, 0);
    bus0.i_req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD port 0: 0x0000FFFF + 1
    bus0.i_req_valid = 2'b01; bus0.i_req_op0 = 3'b000;
    bus0.i_req_a0 = 32'h0000FFFF; bus0.i_req_b0 = 32'h00000001;
    #1 chk("add_ready", bus0.o_req_ready, 2'b01);
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("add_low_busy", bus0.o_busy, 1);
    chk("add_low_op1", bus0.o_dp_operand_one, 32'hFFFF);
    chk("add_low_op2", bus0.o_dp_operand_two, 32'h0001);
    chk("add_low_cin", bus0.o_dp_carry_in, 0);
    chk("add_low_rsp", bus0.o_rsp_valid, 0);
    @(negedge clk);
    chk("add_high_busy", bus0.o_busy, 1);
    chk("add_high_op1", bus0.o_dp_operand_one, 32'h0000);
    chk("add_high_cin", bus0.o_dp_carry_in, 1);
    @(negedge clk);
    chk("add_rsp_valid", bus0.o_rsp_valid, 1);
    chk("add_rsp_result", bus0.o_rsp_result, 32'h00010000);
    chk("add_rsp_carry", bus0.o_rsp_carry, 0);
    chk("add_rsp_id", bus0.o_rsp_id, 0);
    chk("add_rsp_err", bus0.o_rsp_err, 0);
    chk("add_done_busy", bus0.o_busy, 0);
    @(negedge clk);
    chk("add_idle_rsp", bus0.o_rsp_valid, 0);

    // SUB port 1: 5 - 7
    bus0.i_req_valid = 2'b10; bus0.i_req_op1 = 3'b001;
    bus0.i_req_a1 = 32'd5; bus0.i_req_b1 = 32'd7;
    #1 chk("sub1_ready", bus0.o_req_ready, 2'b10);
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("sub1_low_cin", bus0.o_dp_carry_in, 1);
    chk("sub1_low_op2", bus0.o_dp_operand_two, 32'hFFF8);
    chk("sub1_low_sel", bus0.o_dp_op_sel, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("sub1_result", bus0.o_rsp_result, 32'hFFFFFFFE);
    chk("sub1_carry", bus0.o_rsp_carry, 0);
    chk("sub1_id", bus0.o_rsp_id, 1);
    @(negedge clk);

    // SUB port 1: 7 - 5
    bus0.i_req_valid = 2'b10; bus0.i_req_a1 = 32'd7; bus0.i_req_b1 = 32'd5;
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("sub2_low_cin", bus0.o_dp_carry_in, 1);
    @(negedge clk);
    chk("sub2_high_cin", bus0.o_dp_carry_in, 1);
    @(negedge clk);
    chk("sub2_result", bus0.o_rsp_result, 32'h00000002);
    chk("sub2_carry", bus0.o_rsp_carry, 1);
    @(negedge clk);

    // Round robin: both ports hold ADD valid; pointer is back at port 0
    bus0.i_req_op0 = 3'b000; bus0.i_req_a0 = 32'd1;  bus0.i_req_b0 = 32'd2;
    bus0.i_req_op1 = 3'b000; bus0.i_req_a1 = 32'd10; bus0.i_req_b1 = 32'd20;
    bus0.i_req_valid = 2'b11;
    #1 chk("rr_ready0", bus0.o_req_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_low_ready", bus0.o_req_ready, 2'b00);
      @(negedge clk);
      chk("rr_high_ready", bus0.o_req_ready, 2'b00);
      @(negedge clk);
      chk("rr_rsp_valid", bus0.o_rsp_valid, 1);
      chk("rr_rsp_id", bus0.o_rsp_id, k % 2);
      chk("rr_rsp_result", bus0.o_rsp_result, (k % 2) ? 32'd30 : 32'd3);
      chk("rr_done_ready", bus0.o_req_ready, (k % 2) ? 2'b01 : 2'b10);
    end
    bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("rr_end_rsp", bus0.o_rsp_valid, 0);

    // Fixed priority instance: port 0 always wins
    bus1.i_req_op0 = 3'b000; bus1.i_req_a0 = 32'd1;  bus1.i_req_b0 = 32'd2;
    bus1.i_req_op1 = 3'b000; bus1.i_req_a1 = 32'd10; bus1.i_req_b1 = 32'd20;
    bus1.i_req_valid = 2'b11;
    #1 chk("fp_ready0", bus1.o_req_ready, 2'b01);
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      chk("fp_rsp_valid", bus1.o_rsp_valid, 1);
      chk("fp_rsp_id", bus1.o_rsp_id, 0);
      chk("fp_rsp_result", bus1.o_rsp_result, 32'd3);
      chk("fp_done_ready", bus1.o_req_ready, 2'b01);
    end
    bus1.i_req_valid = 2'b00;
    @(negedge clk);

    // XOR port 0
    bus0.i_req_valid = 2'b01; bus0.i_req_op0 = 3'b100;
    bus0.i_req_a0 = 32'hFFFF0000; bus0.i_req_b0 = 32'h0F0F0F0F;
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("xor_low_sel", bus0.o_dp_op_sel, 2'b11);
    chk("xor_low_cin", bus0.o_dp_carry_in, 0);
    @(negedge clk);
    chk("xor_high_sel", bus0.o_dp_op_sel, 2'b11);
    chk("xor_high_cin", bus0.o_dp_carry_in, 0);
    @(negedge clk);
    chk("xor_result", bus0.o_rsp_result, 32'hF0F00F0F);
    chk("xor_carry", bus0.o_rsp_carry, 0);
    @(negedge clk);

    // Illegal op 111: responds in the next cycle, datapath untouched
    bus0.i_req_valid = 2'b01; bus0.i_req_op0 = 3'b111;
    bus0.i_req_a0 = 32'h12345678; bus0.i_req_b0 = 32'h9ABCDEF0;
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    chk("ill_rsp_valid", bus0.o_rsp_valid, 1);
    chk("ill_err", bus0.o_rsp_err, 1);
    chk("ill_result", bus0.o_rsp_result, 0);
    chk("ill_carry", bus0.o_rsp_carry, 0);
    chk("ill_busy", bus0.o_busy, 0);
    chk("ill_dp_op1", bus0.o_dp_operand_one, 0);
    chk("ill_dp_sel", bus0.o_dp_op_sel, 0);
    @(negedge clk);
    chk("ill_after_rsp", bus0.o_rsp_valid, 0);
    chk("ill_after_err", bus0.o_rsp_err, 0);

    // Reset during HIGH drops the operation
    bus0.i_req_valid = 2'b01; bus0.i_req_op0 = 3'b000;
    bus0.i_req_a0 = 32'h0000FFFF; bus0.i_req_b0 = 32'h00000001;
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("mid_high_busy", bus0.o_busy, 1);
    bus0.i_req_valid = 2'b10;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus0.o_busy, 0);
    chk("mid_rst_rsp", bus0.o_rsp_valid, 0);
    chk("mid_rst_op1", bus0.o_dp_operand_one, 0);
    chk("mid_rst_cin", bus0.o_dp_carry_in, 0);
    chk("mid_rst_ready", bus0.o_req_ready, 2'b00);
    @(negedge clk);
    chk("mid_rst_rsp2", bus0.o_rsp_valid, 0);
    bus0.i_req_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", bus0.o_rsp_valid, 0);
    end

    // ADD 1 + 1 after reset release
    bus0.i_req_valid = 2'b01; bus0.i_req_op0 = 3'b000;
    bus0.i_req_a0 = 32'd1; bus0.i_req_b0 = 32'd1;
    #1 chk("post_ready", bus0.o_req_ready, 2'b01);
    @(posedge clk); #1 bus0.i_req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("post_rsp_valid", bus0.o_rsp_valid, 1);
    chk("post_result", bus0.o_rsp_result, 32'd2);
    chk("post_id", bus0.o_rsp_id, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_alu_datapath_arbiter.md
# rv32I_alu_datapath_arbiter

Sequencer and arbiter that shares the single 16-bit ALU datapath slice between two 32-bit requesters: port 0 is the execute stage, port 1 is branch/address calculation. Each accepted request runs as two 16-bit passes (low half, then high half) with carry chaining. The two halves are reassembled into one 32-bit response. The block sits between the requesters and the datapath, and is the only driver of the datapath's operand, carry and op-select inputs.

## Interface
- RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 always winning.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  2  per-port request valid; bit r belongs to port r.
- o_req_ready  out  2  per-port accept; a handshake occurs when valid and ready are both high at a rising edge.
- i_req_op0 / i_req_op1  in  3 each  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; any other code is illegal.
- i_req_a0 / i_req_b0, i_req_a1 / i_req_b1  in  32 each  operands.
- o_dp_operand_one / o_dp_operand_two  out  16 each  operands to the datapath.
- o_dp_carry_in  out  1  datapath carry in.
- o_dp_op_sel  out  2  datapath op select, using the package ADD/AND/OR/XOR encodings.
- i_dp_result  in  16  datapath result; combinational, valid in the same cycle.
- i_dp_carry_out  in  1  datapath carry out.
- o_rsp_valid  out  1  one-cycle response pulse; the response path has no backpressure.
- o_rsp_id  out  1  port that owns the response.
- o_rsp_result  out  32  {high half, low half}.
- o_rsp_carry  out  1  final carry: ADD carry-out, or SUB no-borrow; 0 for logic ops.
- o_rsp_err  out  1  set for an illegal op code.
- o_busy  out  1  high in LOW and HIGH.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- Acceptance is possible in IDLE and DONE only. o_req_ready[r] = (IDLE or DONE) and grant[r].
- Grant:
  - If one port is valid, that port is granted.
  - If both are valid, the port named by the priority pointer is granted.
  - With RR_EN=1 the pointer moves to the other port after every handshake. With RR_EN=0 the pointer is held at port 0.
  - ready may depend combinationally on both valids. Requesters must not make valid depend on ready.
  - Once valid is asserted, it and its payload must stay stable until the handshake.
- On handshake, the op, both operands and the port id are captured into internal registers. The next state is LOW for a legal op and DONE for an illegal op.
- LOW:
  - o_dp_operand_one = a[15:0]; o_dp_operand_two = b[15:0], inverted for SUB.
  - o_dp_carry_in = 1 for SUB, otherwise 0.
  - i_dp_result and i_dp_carry_out are registered; next state HIGH.
- HIGH:
  - o_dp_operand_one = a[31:16]; o_dp_operand_two = b[31:16], inverted for SUB.
  - o_dp_carry_in = the carry registered in LOW for ADD/SUB, otherwise 0.
  - The high result and carry are registered; next state DONE.
- o_dp_op_sel = ADD for ADD and SUB; AND, OR, XOR for the matching ops.
- Outside LOW and HIGH, the datapath outputs are operands 0, carry_in 0, op_sel ADD.
- DONE:
  - o_rsp_valid=1 with registered id, result and carry.
  - A legal op gives o_rsp_err=0. An illegal op gives result 0, carry 0, o_rsp_err=1, and the datapath is not used.
  - Next state is LOW or DONE if a handshake occurs in this cycle, otherwise IDLE.
- Outside DONE, o_rsp_* are held at 0.
- Reset (async assert, sync release): state IDLE, pointer to port 0, every output and register 0.
  - Reset mid-operation drops the operation with no response.
  - Ready is low while i_rst_n is low.

## Timing
- Handshake at edge t0 gives LOW in cycle t0–t1, HIGH in t1–t2, and o_rsp_valid high in t2–t3.
- Latency from handshake to response is 3 cycles; an illegal op responds in 1 cycle.
- Back-to-back throughput is one legal op per 3 cycles, because a new request is accepted in the DONE cycle.
- If both ports are valid in the same cycle, exactly one handshake occurs. The loser's ready stays low until the next IDLE or DONE cycle.
- A request that arrives during LOW or HIGH waits, with ready low, until the DONE cycle.

## Test plan
- ADD on port 0, a=0x0000FFFF, b=0x00000001 -> handshake, o_busy for 2 cycles, then rsp result 0x00010000, carry 0, id 0, 3 cycles after the handshake.
- SUB on port 1, a=5, b=7 -> result 0xFFFFFFFE, carry 0. Then a=7, b=5 -> result 0x00000002, carry 1. Check o_dp_carry_in=1 in LOW.
- Both ports hold ADD valid continuously with RR_EN=1 -> grants alternate 0,1,0,1, one response every 3 cycles. With RR_EN=0 -> only port 0 is granted.
- XOR a=0xFFFF0000, b=0x0F0F0F0F -> result 0xF0F00F0F, carry 0, o_dp_op_sel=XOR in LOW and HIGH, o_dp_carry_in=0.
- Illegal op 111 -> response on the next cycle with err=1, result 0; datapath outputs stay at their idle values.
- Assert i_rst_n low during HIGH -> no rsp_valid; all outputs 0 immediately. After release, a new ADD 1+1 returns 2.
